avr_io_intc: RTL and testbench

AVR_IO_INTC -- requirements
Module: avr_io_intc

---
 rtl/avr_io_pkg.sv | 14 +
 rtl/avr_irq_prio_enc.sv | 25 ++
 rtl/avr_io_intc.sv | 110 +++++++++++
 tb/tb_avr_io_intc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/avr_io_pkg.sv
// Shared constants for the AVR IO interrupt controller: the register map and source-count limits.
package avr_io_pkg;

    localparam int unsigned MIN_IRQ = 2;
    localparam int unsigned MAX_IRQ = 8;

    typedef enum logic [1:0] {
        REG_IMSK  = 2'd0,
        REG_IPEND = 2'd1,
        REG_IMODE = 2'd2,
        REG_IPOL  = 2'd3
    } io_reg_e;

endpackage

// File: rtl/avr_irq_prio_enc.sv
// Fixed-priority encoder: the lowest-index set request wins.
module avr_irq_prio_enc #(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned VECT_W  = 3
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               any_o,
    output logic [VECT_W-1:0]  idx_o
);

    logic found;

    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (req_i[i] && !found) begin
                idx_o = VECT_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/avr_io_intc.sv
// AVR IO-mapped interrupt controller: mask, pending, edge/level mode and polarity per source,
// with a registered request flag and vector of the lowest-index active source.
module avr_io_intc
    import avr_io_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 8,
    parameter int unsigned VECT_W  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               io_re,
    input  logic               io_we,
    input  logic [1:0]         io_a,
    input  logic [7:0]         io_do,
    output logic [7:0]         io_di,
    input  logic [NUM_IRQ-1:0] irq_src,
    output logic               iflag,
    output logic [VECT_W-1:0]  ivect
);

    logic [NUM_IRQ-1:0] imsk_q, imsk_d;
    logic [NUM_IRQ-1:0] imode_q, imode_d;
    logic [NUM_IRQ-1:0] ipol_q, ipol_d;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] act_q;
    logic               iflag_q;
    logic [VECT_W-1:0]  ivect_q;

    logic [NUM_IRQ-1:0] wdata;
    logic [NUM_IRQ-1:0] act;
    logic [NUM_IRQ-1:0] edge_set;
    logic [NUM_IRQ-1:0] ipend_view;
    logic [NUM_IRQ-1:0] req;
    logic               req_any;
    logic [VECT_W-1:0]  req_idx;
    logic [7:0]         rd_data;

    assign wdata    = io_do[NUM_IRQ-1:0];
    assign act      = irq_src ^ ipol_q;
    assign edge_set = act & ~act_q & imode_q;
    // Level-mode bits expose the live source; only edge-mode bits have latched state.
    assign ipend_view = (pend_q & imode_q) | (act & ~imode_q);
    assign req        = ipend_view & imsk_q;

    always_comb begin
        imsk_d  = imsk_q;
        imode_d = imode_q;
        ipol_d  = ipol_q;
        pend_d  = pend_q;
        if (io_we) begin
            unique case (io_reg_e'(io_a))
                REG_IMSK:  imsk_d = wdata;
                REG_IPEND: pend_d = pend_q & ~wdata;
                REG_IMODE: begin
                    imode_d = wdata;
                    pend_d  = pend_q & ~(wdata ^ imode_q);
                end
                REG_IPOL:  ipol_d = wdata;
            endcase
        end
        // New edges override a same-cycle clear; bits leaving edge mode hold nothing.
        pend_d = (pend_d | edge_set) & imode_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imsk_q  <= '0;
            imode_q <= '0;
            ipol_q  <= '0;
            pend_q  <= '0;
            act_q   <= '0;
            iflag_q <= 1'b0;
            ivect_q <= '0;
        end else begin
            imsk_q  <= imsk_d;
            imode_q <= imode_d;
            ipol_q  <= ipol_d;
            pend_q  <= pend_d;
            act_q   <= act;
            iflag_q <= req_any;
            if (req_any) begin
                ivect_q <= req_idx;
            end
        end
    end

    avr_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .VECT_W  (VECT_W)
    ) u_prio (
        .req_i (req),
        .any_o (req_any),
        .idx_o (req_idx)
    );

    always_comb begin
        rd_data = '0;
        unique case (io_reg_e'(io_a))
            REG_IMSK:  rd_data = 8'(imsk_q);
            REG_IPEND: rd_data = 8'(ipend_view);
            REG_IMODE: rd_data = 8'(imode_q);
            REG_IPOL:  rd_data = 8'(ipol_q);
        endcase
    end

    assign io_di = io_re ? rd_data : 8'h00;
    assign iflag = iflag_q;
    assign ivect = ivect_q;

endmodule

// File: tb/tb_avr_io_intc.sv
// Scoreboard bench for avr_io_intc: an 8-source and a 4-source instance share the clock and reset.
module tb_avr_io_intc;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       re8, we8, re4, we4;
    logic [1:0] io_a;
    logic [7:0] io_do;
    logic [7:0] di8, di4;
    logic [7:0] src8;
    logic [3:0] src4;
    logic       iflag8, iflag4;
    logic [2:0] ivect8;
    logic [1:0] ivect4;
    logic       fchk8, fchk4;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rd_q[$];
    string      rd_n[$];
    logic [7:0] fl_q[$];
    string      fl_n[$];

    always #5 clk = ~clk;

    avr_io_intc #(.NUM_IRQ(8), .VECT_W(3)) dut8 (
        .clk(clk), .reset_n(reset_n), .io_re(re8), .io_we(we8), .io_a(io_a),
        .io_do(io_do), .io_di(di8), .irq_src(src8), .iflag(iflag8), .ivect(ivect8)
    );

    avr_io_intc #(.NUM_IRQ(4), .VECT_W(2)) dut4 (
        .clk(clk), .reset_n(reset_n), .io_re(re4), .io_we(we4), .io_a(io_a),
        .io_do(io_do), .io_di(di4), .irq_src(src4), .iflag(iflag4), .ivect(ivect4)
    );

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Flag word: iflag in bit 7, ivect in the low bits.
    always @(negedge clk) begin
        if (re8 || re4) begin
            if (rd_q.size() == 0) begin
                failures++;
                $display("FAIL rd_underflow: got read with no expected value");
            end else begin
                check(rd_n.pop_front(), re4 ? di4 : di8, rd_q.pop_front());
            end
        end
        if (fchk8 || fchk4) begin
            if (fl_q.size() == 0) begin
                failures++;
                $display("FAIL flag_underflow: got flag sample with no expected value");
            end else begin
                check(fl_n.pop_front(),
                      fchk4 ? {iflag4, 5'b0, ivect4} : {iflag8, 4'b0, ivect8},
                      fl_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        re8 = 0; we8 = 0; re4 = 0; we4 = 0; fchk8 = 0; fchk4 = 0;
    endtask

    task automatic exp_rd(input logic four, input logic [1:0] a, input logic [7:0] e, input string nm);
        if (four) re4 = 1; else re8 = 1;
        io_a = a;
        rd_q.push_back(e);
        rd_n.push_back(nm);
    endtask

    task automatic exp_fl(input logic four, input logic [7:0] e, input string nm);
        if (four) fchk4 = 1; else fchk8 = 1;
        fl_q.push_back(e);
        fl_n.push_back(nm);
    endtask

    task automatic wr(input logic four, input logic [1:0] a, input logic [7:0] d);
        if (four) we4 = 1; else we8 = 1;
        io_a  = a;
        io_do = d;
        cyc();
        idle();
    endtask

    task automatic rd(input logic four, input logic [1:0] a, input logic [7:0] e, input string nm);
        exp_rd(four, a, e, nm);
        cyc();
        idle();
    endtask

    task automatic fl(input logic four, input logic [7:0] e, input string nm);
        exp_fl(four, e, nm);
        cyc();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; idle(); io_a = 0; io_do = 0; src8 = 0; src4 = 0;
        cyc(); cyc();
        rd(0, 0, 8'h00, "rst_imsk");
        rd(0, 1, 8'h00, "rst_ipend");
        rd(0, 2, 8'h00, "rst_imode");
        rd(0, 3, 8'h00, "rst_ipol");
        fl(0, 8'h00, "rst_flag");

        // Source already active at reset release: level view only, no edge later.
        src8 = 8'h01; cyc();
        reset_n = 1; cyc();
        rd(0, 1, 8'h01, "lvl_live");
        wr(0, 2, 8'hFF);
        rd(0, 1, 8'h00, "no_edge_at_release");
        rd(0, 2, 8'hFF, "imode_rb");
        src8 = 8'h00;
        wr(0, 0, 8'hFF);
        cyc();
        fl(0, 8'h00, "idle_flag");

        // One-cycle pulse on source 5
        src8 = 8'h20; cyc();
        src8 = 8'h00; cyc();
        exp_fl(0, 8'h85, "b5_flag");
        exp_rd(0, 1, 8'h20, "b5_pend");
        cyc(); idle();
        wr(0, 1, 8'h20);
        cyc();
        fl(0, 8'h05, "b5_clr_flag_hold_vect");
        rd(0, 1, 8'h00, "b5_clr_pend");

        // Sources 2 and 6 together: 2 wins, then 6 after clearing 2
        src8 = 8'h44; cyc();
        src8 = 8'h00; cyc();
        fl(0, 8'h82, "p2_win");
        rd(0, 1, 8'h44, "p26_pend");
        wr(0, 1, 8'h04);
        fl(0, 8'h82, "p2_clr_flag_stays");
        fl(0, 8'h86, "p6_win");
        wr(0, 1, 8'h40);
        cyc();
        fl(0, 8'h06, "p6_clr");

        // Masked source still latches
        wr(0, 0, 8'h00);
        src8 = 8'h80; cyc();
        src8 = 8'h00; cyc();
        exp_rd(0, 1, 8'h80, "masked_pend");
        exp_fl(0, 8'h06, "masked_flag");
        cyc(); idle();
        wr(0, 0, 8'h80);
        cyc();
        fl(0, 8'h87, "unmask_flag");
        wr(0, 1, 8'hFF);
        cyc();
        fl(0, 8'h07, "clr_all");

        // Edge and clear of bit 1 in the same cycle: set wins
        src8 = 8'h02; we8 = 1; io_a = 1; io_do = 8'h02;
        cyc(); idle();
        rd(0, 1, 8'h02, "set_wins");
        src8 = 8'h00;
        wr(0, 1, 8'h02);
        rd(0, 1, 8'h00, "b1_clr");

        // Mode change clears only the bits whose mode changes
        src8 = 8'h30; cyc();
        src8 = 8'h00; cyc();
        rd(0, 1, 8'h30, "b45_pend");
        wr(0, 2, 8'hEF);
        rd(0, 1, 8'h20, "mode_chg_clr");
        wr(0, 2, 8'hFF);
        rd(0, 1, 8'h20, "mode_back_no_resurrect");
        wr(0, 1, 8'hFF);

        // Inverted level source 3
        wr(0, 2, 8'h00);
        wr(0, 3, 8'h08);
        wr(0, 0, 8'hFF);
        rd(0, 1, 8'h08, "inv_lvl_pend");
        fl(0, 8'h83, "inv_lvl_flag");
        rd(0, 3, 8'h08, "ipol_rb");
        src8 = 8'h08; cyc();
        exp_fl(0, 8'h03, "inv_lvl_fall");
        exp_rd(0, 1, 8'h00, "inv_lvl_clr");
        cyc(); idle();

        // Four-source instance: unused bits and async reset
        wr(1, 0, 8'hFF);
        rd(1, 0, 8'h0F, "n4_imsk");
        wr(1, 2, 8'hFF);
        rd(1, 2, 8'h0F, "n4_imode");
        src4 = 4'h4; cyc();
        src4 = 4'h0; cyc();
        fl(1, 8'h82, "n4_flag");
        @(posedge clk);
        #3;
        reset_n = 0;
        #1;
        check("n4_async_rst_flag", {iflag4, 5'b0, ivect4}, 8'h00);
        rd(1, 0, 8'h00, "n4_rst_imsk");
        rd(1, 1, 8'h00, "n4_rst_ipend");
        rd(1, 2, 8'h00, "n4_rst_imode");
        rd(1, 3, 8'h00, "n4_rst_ipol");
        rd(0, 3, 8'h00, "n8_rst_ipol");
        fl(0, 8'h00, "n8_rst_flag");

        if (rd_q.size() != 0 || fl_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d/%0d left expected 0/0", rd_q.size(), fl_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
